seg_disp_sched: RTL and testbench
=================================

SEG_DISP_SCHED -- requirements
Module: seg_disp_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the two-digit 7-segment display (2..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50000000, clock cycles one granted byte stays displayed (>=2).
REQ-003 SHALL have parameter BLINK_DIV, default 12500000, half-period in cycles of the blink feature (only used when SEG_SCHED_BLINK_EN is defined).
REQ-004 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_req_valid, input, NREQ, per-requester display request, held until acked.
REQ-007 SHALL have port i_req_data, input, 8*NREQ, byte of requester k on bits [8k+7:8k].
REQ-008 SHALL have port o_req_ack, output, NREQ, one-cycle acknowledge to the granted requester.
REQ-009 SHALL have port o_data, output, 8, byte forwarded to the 7-segment decoder.
REQ-010 SHALL have port o_data_valid, output, 1, one-cycle load strobe to the decoder.
REQ-011 SHALL have port o_en, output, 1, decoder enable; 0 blanks the digits.
REQ-012 SHALL have port o_grant, output, 3, index of the current or last owner.
REQ-013 SHALL have port o_busy, output, 1, high while in HOLD.

Function
REQ-014 SHALL implement FSM states IDLE and HOLD; all outputs registered.
REQ-015 In IDLE with any i_req_valid bit set at edge N, SHALL at edge N+1: select winner g, drive o_req_ack[g]=1, o_data=i_req_data[g], o_data_valid=1, o_grant=g, o_en=1, enter HOLD with counter=HOLD_CYCLES-1.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ and wraps; a requester is never granted twice in a row while another is valid.
REQ-017 o_req_ack and o_data_valid SHALL be high exactly one cycle per grant.
REQ-018 In HOLD, counter SHALL decrement each cycle; on counter==0 the FSM returns to IDLE at the next edge; total HOLD dwell = HOLD_CYCLES cycles.
REQ-019 Requests arriving or held during HOLD SHALL be neither acked nor lost; they compete at the first IDLE cycle.
REQ-020 A requester dropping i_req_valid before ack SHALL never be granted.
REQ-021 In IDLE with no request, o_data, o_grant and o_en SHALL hold their values (last byte stays displayed).
REQ-022 o_busy SHALL equal (state==HOLD).

Reset
REQ-023 i_reset SHALL asynchronously force: state IDLE, counter 0, o_req_ack 0, o_data 8'h00, o_data_valid 0, o_en 0, o_grant 0, last_grant NREQ-1 (requester 0 has first priority), blink phase 0.
REQ-024 Reset asserted mid-HOLD SHALL abort the hold; the first request after release is granted per REQ-015.

Configuration
REQ-025 With macro SEG_SCHED_BLINK_EN defined: in HOLD, o_en SHALL toggle every BLINK_DIV cycles starting at 1 on grant; o_en forced to 1 on return to IDLE.
REQ-026 Without SEG_SCHED_BLINK_EN: no blink counter synthesized; o_en per REQ-015/021 only.

Structure
REQ-027 Package seg_sched_pkg SHALL hold the FSM state encoding (IDLE=1'b0, HOLD=1'b1) and NREQ_MAX=8.
REQ-028 Round-robin selection SHALL live in sub-module seg_rr_arb (inputs req, last_grant; outputs grant index, any_valid), purely combinational.

Verification (bench: NREQ=4, HOLD_CYCLES=4, BLINK_DIV=2)
REQ-029 Reset, single request: req=4'b0001, data0=8'h3A -> one cycle later ack=4'b0001, o_data=8'h3A, o_data_valid=1, o_en=1, o_grant=0; o_busy high 4 cycles.
REQ-030 Contention: req=4'b1111 held with data k=8'h10+k -> grants in order 0,1,2,3,0, each 5 cycles apart, one ack each.
REQ-031 Request during HOLD: req1 raised 1 cycle after grant0 -> req1 acked only at first IDLE cycle, no ack during HOLD.
REQ-032 Withdrawn request: req2 pulsed 1 cycle inside HOLD -> never acked; o_data unchanged 8'h3A.
REQ-033 Reset mid-HOLD at counter=2 -> all outputs 0 immediately, o_en=0; next req3 granted per REQ-015.
REQ-034 With SEG_SCHED_BLINK_EN: grant -> o_en pattern 1,1,0,0 across HOLD, 1 in IDLE.

Source files
------------

// File: rtl/seg_sched_pkg.sv
// Shared definitions for the segment display scheduler: FSM encoding,
// grant index width and a counter-width helper.
package seg_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NREQ_MAX = 8;
  localparam int GRANT_W  = $clog2(NREQ_MAX);

  // Bits needed to hold a down-counter loaded with n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_rr_arb.sv
// Combinational round-robin picker: the search starts one past last_grant
// and wraps, so the previous owner has the lowest priority.
module seg_rr_arb
  import seg_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] grant,
  output logic               any_valid
);

  localparam int SW = GRANT_W + 1;

  logic [SW-1:0]   start;
  logic [NREQ-1:0] rot;

  // Rotate req so bit 0 is the first candidate, then take the lowest set bit.
  always_comb begin
    start = {1'b0, last_grant} + SW'(1);
    if (start >= SW'(NREQ)) start = '0;
    rot       = NREQ'({req, req} >> start);
    grant     = '0;
    any_valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any_valid = 1'b1;
        grant     = GRANT_W'((int'(start) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Time-shares a two-digit 7-segment display among NREQ requesters.
// A granted byte is shown for HOLD_CYCLES cycles; between holds the last
// byte stays on the display.
// Optional macro SEG_SCHED_BLINK_EN: blink the display during a hold with
// a half-period of BLINK_DIV cycles.
module seg_disp_sched
  import seg_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [8*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ack,
  output logic [7:0]        o_data,
  output logic              o_data_valid,
  output logic              o_en,
  output logic [2:0]        o_grant,
  output logic              o_busy
);

  localparam int CW = cnt_w(HOLD_CYCLES);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [GRANT_W-1:0]     last_grant;
  logic [GRANT_W-1:0]     win;
  logic                   any_valid;
  logic [NREQ-1:0][7:0]   req_bytes;
  logic [7:0]             win_data;
  logic [NREQ-1:0]        win_onehot;

`ifdef SEG_SCHED_BLINK_EN
  localparam int BW = cnt_w(BLINK_DIV);
  logic [BW-1:0] blink_cnt;
`endif

  assign req_bytes = i_req_data;
  assign o_busy    = (state == HOLD);

  seg_rr_arb #(.NREQ(NREQ)) u_arb (
    .req        (i_req_valid),
    .last_grant (last_grant),
    .grant      (win),
    .any_valid  (any_valid)
  );

  // Decode the winner index into its ack bit and its byte.
  always_comb begin
    win_data   = '0;
    win_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == GRANT_W'(k)) begin
        win_onehot[k] = 1'b1;
        win_data      = req_bytes[k];
      end
    end
  end

  // IDLE/HOLD scheduler; ack and load strobe are single-cycle pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      o_req_ack    <= '0;
      o_data       <= 8'h00;
      o_data_valid <= 1'b0;
      o_en         <= 1'b0;
      o_grant      <= '0;
      last_grant   <= GRANT_W'(NREQ - 1);
`ifdef SEG_SCHED_BLINK_EN
      blink_cnt    <= '0;
`endif
    end else begin
      o_req_ack    <= '0;
      o_data_valid <= 1'b0;
      if (state == IDLE) begin
        if (any_valid) begin
          o_req_ack    <= win_onehot;
          o_data       <= win_data;
          o_data_valid <= 1'b1;
          o_grant      <= win;
          o_en         <= 1'b1;
          last_grant   <= win;
          cnt          <= CW'(HOLD_CYCLES - 1);
          state        <= HOLD;
`ifdef SEG_SCHED_BLINK_EN
          blink_cnt    <= BW'(BLINK_DIV - 1);
`endif
        end
      end else begin
        if (cnt == '0) begin
          state <= IDLE;
`ifdef SEG_SCHED_BLINK_EN
          o_en  <= 1'b1;
`endif
        end else begin
          cnt <= cnt - CW'(1);
`ifdef SEG_SCHED_BLINK_EN
          if (blink_cnt == '0) begin
            o_en      <= ~o_en;
            blink_cnt <= BW'(BLINK_DIV - 1);
          end else begin
            blink_cnt <= blink_cnt - BW'(1);
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: directed scenarios with literal expectations
// plus a randomized requester phase, all checked every cycle against a
// behavioural model (remaining-dwell count + rotating priority search).
module tb_seg_disp_sched;

  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam int BDIV = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [7:0]        odata;
  logic              dv, en, busy;
  logic [2:0]        grant;

  int n_chk  = 0;
  int n_fail = 0;
  bit model_on = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg_disp_sched #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .BLINK_DIV(BDIV)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (req),
    .i_req_data   (data),
    .o_req_ack    (ack),
    .o_data       (odata),
    .o_data_valid (dv),
    .o_en         (en),
    .o_grant      (grant),
    .o_busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [NREQ-1:0] ack;
    logic [7:0]      data;
    logic            dv;
    logic            en;
    int              grant;
    int              left;   // hold cycles still to be shown
    int              last;
  } mstate_t;

  mstate_t ms;

  function automatic mstate_t model_reset();
    mstate_t n;
    n.ack = '0; n.data = 8'h00; n.dv = 1'b0; n.en = 1'b0;
    n.grant = 0; n.left = 0; n.last = NREQ - 1;
    return n;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [NREQ-1:0] r,
                                         input logic [8*NREQ-1:0] d);
    mstate_t n = s;
    n.ack = '0;
    n.dv  = 1'b0;
    if (s.left > 0) begin
      n.left = s.left - 1;
`ifdef SEG_SCHED_BLINK_EN
      n.en = (n.left == 0) || (((HOLD - n.left) / BDIV) % 2 == 0);
`endif
    end else begin
      for (int i = 1; i <= NREQ; i++) begin
        int k = (s.last + i) % NREQ;
        if (!n.dv && r[k]) begin
          n.dv     = 1'b1;
          n.ack[k] = 1'b1;
          n.data   = d[8*k +: 8];
          n.en     = 1'b1;
          n.grant  = k;
          n.last   = k;
          n.left   = HOLD;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) ms <= model_reset();
    else     ms <= model_step(ms, req, data);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      check("m_ack",   32'(ack),   32'(ms.ack));
      check("m_data",  32'(odata), 32'(ms.data));
      check("m_dv",    32'(dv),    32'(ms.dv));
      check("m_en",    32'(en),    32'(ms.en));
      check("m_grant", 32'(grant), 32'(ms.grant));
      check("m_busy",  32'(busy),  32'(ms.left > 0));
    end
  end

  // ---------------- stimulus ----------------
  int busy_cnt, cyc, ng, idx, prev_t;
  bit seen2, early;
  int gidx [$];
  int gtim [$];

  initial begin
    rst  = 1'b0;
    req  = '0;
    data = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    model_on = 1;

    // reset state
    check("rst_ack",   32'(ack),   32'h0);
    check("rst_data",  32'(odata), 32'h0);
    check("rst_dv",    32'(dv),    32'h0);
    check("rst_en",    32'(en),    32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    rst = 1'b0;
    @(negedge clk);

    // single request from requester 0
    data[7:0] = 8'h3A;
    req = 4'b0001;
    @(negedge clk);
    check("t1_ack",   32'(ack),   32'h1);
    check("t1_data",  32'(odata), 32'h3A);
    check("t1_dv",    32'(dv),    32'h1);
    check("t1_en",    32'(en),    32'h1);
    check("t1_grant", 32'(grant), 32'h0);
    check("t1_busy",  32'(busy),  32'h1);
    busy_cnt = 1;
    // requester 2 pulses for one cycle inside the hold
    req = 4'b0100;
    data[23:16] = 8'hC5;
    @(negedge clk);
    req = 4'b0000;
    check("t1_dv_pulse", 32'(dv), 32'h0);
    busy_cnt += int'(busy);
    seen2 = ack[2];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      seen2 |= ack[2];
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'd4);
    check("t2w_no_ack",     32'(seen2),    32'h0);
    check("t2w_data_kept",  32'(odata),    32'h3A);
    check("t2w_en_kept",    32'(en),       32'h1);

    // request during hold: req1 raised one cycle after grant of req0
    req = 4'b0001;
    @(negedge clk);
    check("t3_ack0", 32'(ack), 32'h1);
    req = 4'b0010;
    data[15:8] = 8'h55;
    cyc = 0;
    early = 0;
    for (int i = 1; i <= 10 && cyc == 0; i++) begin
      @(negedge clk);
      if (ack[1]) cyc = i;
      else if (ack != '0) early = 1;
    end
    check("t3_ack1_cycle", 32'(cyc),   32'd5);
    check("t3_no_stray",   32'(early), 32'h0);
    check("t3_data",       32'(odata), 32'h55);
    check("t3_grant",      32'(grant), 32'h1);
    req = 4'b0000;

    // reset mid-hold with counter at 2
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_ack",   32'(ack),   32'h0);
    check("t4_data",  32'(odata), 32'h0);
    check("t4_dv",    32'(dv),    32'h0);
    check("t4_en",    32'(en),    32'h0);
    check("t4_grant", 32'(grant), 32'h0);
    check("t4_busy",  32'(busy),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req = 4'b1000;
    data[31:24] = 8'hA7;
    @(negedge clk);
    check("t4_ack3",   32'(ack),   32'h8);
    check("t4_grant3", 32'(grant), 32'h3);
    check("t4_data3",  32'(odata), 32'hA7);
    check("t4_busy3",  32'(busy),  32'h1);
    req = 4'b0000;
    repeat (5) @(negedge clk);

    // contention: all four held, expect 0,1,2,3,0 five cycles apart
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req  = 4'b1111;
    ng   = 0;
    for (int i = 1; i <= 30 && ng < 5; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        idx = -1;
        for (int k = 0; k < NREQ; k++) if (ack[k]) idx = k;
        check("t5_onehot", 32'($countones(ack)), 32'd1);
        check("t5_byte",   32'(odata), 32'(8'h10 + idx));
        gidx.push_back(idx);
        gtim.push_back(i);
        ng++;
      end
    end
    check("t5_count", 32'(ng), 32'd5);
    prev_t = -1;
    for (int j = 0; j < gidx.size(); j++) begin
      check("t5_order", 32'(gidx[j]), 32'(j % NREQ));
      if (prev_t >= 0) check("t5_spacing", 32'(gtim[j] - prev_t), 32'd5);
      prev_t = gtim[j];
    end
    req = 4'b0000;

    // randomized requesters with occasional withdrawals and resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (req[k] && ack[k]) req[k] = 1'b0;
        else if (req[k] && $urandom_range(0, 39) == 0) req[k] = 1'b0;
        else if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
          data[8*k +: 8] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    model_on = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
